cla16_mul_seq: RTL

- Sequential 16x16 unsigned shift-add multiplier that owns one cla_16 instance and steps it once per cycle.
- Sits beside the ALU as the multi-cycle multiply unit (RV32M MULHU/MUL low-half path for 16-bit operands).
- Uses valid/ready handshakes on input and output.
- Produces a 32-bit product; the controller sequences the adder, carry capture, shift and iteration count.

---
 rtl/cla16_mul_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cla16_mul_seq.sv
// 16x16 unsigned shift-add multiplier stepping one 16-bit carry-lookahead adder per cycle.
// Build option: define MUL_ZERO_SKIP_EN to finish zero-operand multiplies without iterating.

module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        gx,
  output logic        px
);
  logic [15:0] g, p, carry;
  logic [3:0]  gg, pg, c;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    c[0] = cin;
    for (int j = 0; j < 3; j++) c[j+1] = gg[j] | (pg[j] & c[j]);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) carry[i] = c[i/4];
      else            carry[i] = g[i-1] | (p[i-1] & carry[i-1]);
    end
    sum = p ^ carry;
    gx  = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
    px  = &pg;
  end
endmodule

module cla16_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  if (WIDTH != 16 || (1 << CNT_W) <= WIDTH) begin : g_param_check
    $error("cla16_mul_seq: WIDTH must be 16 and CNT_W must hold WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     add_b, sum, acc_sh, q_sh;
  logic                 gx, px, cin, cout;

  assign cin   = 1'b0;
  assign add_b = q_q[0] ? m_q : '0;

  cla_16 u_cla (.a(acc_q), .b(add_b), .cin(cin), .sum(sum), .gx(gx), .px(px));

  // The carry C is taken straight from cout into A[15] as the 33-bit {C,A,Q} shifts right.
  assign cout           = gx | (px & cin);
  assign {acc_sh, q_sh} = {cout, sum, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MUL_ZERO_SKIP_EN
          if (a == '0 || b == '0) begin
            product_d = '0;
            state_d   = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = {acc_sh, q_sh};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign product   = product_q;
endmodule
